// File: rtl/id_issue_buf_pkg.sv
// Shared CPU header for the decode/issue boundary.
// Holds the packed decoded-instruction bundle layout (field offsets and
// widths), the memory-op encoding and the "no exception" code. Every block
// that slices a bundle imports this package rather than hard-coding offsets.
package id_issue_buf_pkg;

   // Bundle layout, LSB first. Bits above ISA_EXP field are spare.
   localparam int ISA_PC_LSB       = 0;
   localparam int ISA_PC_W         = 32;
   localparam int ISA_ALU_OP_LSB   = 32;
   localparam int ISA_ALU_OP_W     = 4;
   localparam int ISA_ALU_IN0_LSB  = 36;
   localparam int ISA_ALU_IN0_W    = 16;
   localparam int ISA_ALU_IN1_LSB  = 52;
   localparam int ISA_ALU_IN1_W    = 16;
   localparam int ISA_BR_BIT       = 68;
   localparam int ISA_MEM_OP_LSB   = 69;
   localparam int ISA_MEM_OP_W     = 3;
   localparam int ISA_WR_DATA_LSB  = 72;
   localparam int ISA_WR_DATA_W    = 16;
   localparam int ISA_CTRL_OP_LSB  = 88;
   localparam int ISA_CTRL_OP_W    = 4;
   localparam int ISA_DST_LSB      = 92;
   localparam int ISA_DST_W        = 5;
   localparam int ISA_GPR_WE_N_BIT = 97;   // active-low GPR write enable
   localparam int ISA_EXP_LSB      = 98;
   localparam int ISA_EXP_W        = 3;

   typedef enum logic [ISA_MEM_OP_W-1:0] {
      MEM_OP_NONE  = 3'd0,
      MEM_OP_LOAD  = 3'd1,
      MEM_OP_STORE = 3'd2
   } mem_op_e;

   localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP = 3'd0;

   function automatic logic is_load(input logic [ISA_MEM_OP_W-1:0] op);
      return mem_op_e'(op) == MEM_OP_LOAD;
   endfunction

endpackage

// File: rtl/id_issue_fifo.sv
// Storage for the issue buffer: a DEPTH-entry FIFO of fixed-width words.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush           - empties the queue at the next edge (dominates push/pop)
//   push, wdata     - write one word (caller guarantees not full)
//   pop             - drop the head word (caller guarantees not empty)
//   rdata           - current head word
//   count           - number of valid words, 0..DEPTH
//   full, empty     - status flags derived from count
module id_issue_fifo
   import id_issue_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
   // the wrap free.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/id_issue_buf.sv
// Decode-to-execute issue buffer: a small skid queue of decoded bundles with
// a load-use interlock on the head entry.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flush                 - drop all entries and any pending load record
//   dec_valid/dec_ready   - decoder handshake; dec_ready is simply not-full
//   dec_bundle            - packed decoded instruction (layout in the package)
//   dec_src0/1, dec_src_use - source registers and which of them are read
//   ex_valid/ex_ready     - execute handshake for the head entry
//   ex_bundle             - head bundle; holds the last presented value when empty
//   ld_hazard             - head is being held by the load-use interlock
//   occupancy             - number of queued entries
// Configuration macro ID_ISSUE_EXP_EN: when defined, the exception field is
// kept and a head with a nonzero exception skips the interlock, is presented
// with its GPR write suppressed, and never arms a load record. When undefined
// the exception field is not stored and reads back as ISA_EXP_NO_EXP.
module id_issue_buf
   import id_issue_buf_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int BUNDLE_W = 128,
   parameter int REG_AW   = 5,
   parameter int LD_LAT   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     dec_valid,
   output logic                     dec_ready,
   input  logic [BUNDLE_W-1:0]      dec_bundle,
   input  logic [REG_AW-1:0]        dec_src0,
   input  logic [REG_AW-1:0]        dec_src1,
   input  logic [1:0]               dec_src_use,
   output logic                     ex_valid,
   input  logic                     ex_ready,
   output logic [BUNDLE_W-1:0]      ex_bundle,
   output logic                     ld_hazard,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int ENTRY_W = BUNDLE_W + 2*REG_AW + 2;
   localparam logic [1:0] LD_CNT_INIT = LD_LAT[1:0];

   logic [ENTRY_W-1:0]  wr_entry;
   logic [ENTRY_W-1:0]  rd_entry;
   logic [BUNDLE_W-1:0] wr_bundle;
   logic [BUNDLE_W-1:0] head_bundle;
   logic [BUNDLE_W-1:0] pres_bundle;
   logic [BUNDLE_W-1:0] last_bundle;
   logic [REG_AW-1:0]   head_src0;
   logic [REG_AW-1:0]   head_src1;
   logic [1:0]          head_use;
   logic [REG_AW-1:0]   ld_dst;
   logic [1:0]          ld_cnt;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                exp_bypass;
   logic                src_hit;
   logic                hazard;
   logic                head_load;

   assign dec_ready = ~full;
   assign push      = dec_valid & ~full & ~flush;

   assign wr_entry = {dec_src_use, dec_src1, dec_src0, wr_bundle};
   assign {head_use, head_src1, head_src0, head_bundle} = rd_entry;

   id_issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .count (occupancy),
      .full  (full),
      .empty (empty)
   );

`ifdef ID_ISSUE_EXP_EN
   assign exp_bypass = (head_bundle[ISA_EXP_LSB +: ISA_EXP_W] != ISA_EXP_NO_EXP);

   always_comb begin
      wr_bundle   = dec_bundle;
      pres_bundle = head_bundle;
      // An excepting instruction must not retire a register write.
      if (exp_bypass) pres_bundle[ISA_GPR_WE_N_BIT] = 1'b1;
   end
`else
   assign exp_bypass = 1'b0;

   always_comb begin
      wr_bundle   = dec_bundle;
      wr_bundle[ISA_EXP_LSB +: ISA_EXP_W] = '0;
      pres_bundle = head_bundle;
      pres_bundle[ISA_EXP_LSB +: ISA_EXP_W] = ISA_EXP_NO_EXP;
   end
`endif

   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign src_hit = (head_use[0] && (head_src0 == ld_dst)) ||
                    (head_use[1] && (head_src1 == ld_dst));
   assign hazard  = ~empty && (ld_cnt != '0) && (ld_dst != '0) && src_hit && ~exp_bypass;

   assign ex_valid  = ~empty & ~hazard;
   assign ld_hazard = hazard;
   assign pop       = ex_valid & ex_ready;
   assign ex_bundle = empty ? last_bundle : pres_bundle;

   assign head_load = is_load(head_bundle[ISA_MEM_OP_LSB +: ISA_MEM_OP_W]) &&
                      !head_bundle[ISA_GPR_WE_N_BIT] && !exp_bypass;

   // Load record: the newest issued load wins; flush clears it even if a load
   // is being popped in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ld_cnt <= '0;
         ld_dst <= '0;
      end else if (pop && head_load) begin
         ld_cnt <= LD_CNT_INIT;
         ld_dst <= head_bundle[ISA_DST_LSB +: REG_AW];
      end else if (ld_cnt != '0) begin
         ld_cnt <= ld_cnt - 1'b1;
      end
   end

   // Keeps ex_bundle stable once the queue drains.
   always_ff @(posedge clk) begin
      if (reset)       last_bundle <= '0;
      else if (!empty) last_bundle <= pres_bundle;
   end

endmodule

// File: tb/tb_id_issue_buf.sv
module tb_id_issue_buf;
   import id_issue_buf_pkg::*;

   localparam int DEPTH    = 4;
   localparam int BUNDLE_W = 128;
   localparam int REG_AW   = 5;
   localparam int LD_LAT   = 2;
   localparam logic [127:0] Z = '0;

   logic                   clk = 1'b0;
   logic                   reset, flush, dec_valid, dec_ready, ex_valid, ex_ready, ld_hazard;
   logic [BUNDLE_W-1:0]    dec_bundle, ex_bundle;
   logic [REG_AW-1:0]      dec_src0, dec_src1;
   logic [1:0]             dec_src_use;
   logic [$clog2(DEPTH):0] occupancy;

   always #5 clk = ~clk;

   id_issue_buf #(
      .DEPTH(DEPTH), .BUNDLE_W(BUNDLE_W), .REG_AW(REG_AW), .LD_LAT(LD_LAT)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_bundle(dec_bundle),
      .dec_src0(dec_src0), .dec_src1(dec_src1), .dec_src_use(dec_src_use),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_bundle(ex_bundle),
      .ld_hazard(ld_hazard), .occupancy(occupancy)
   );

   // Reference model: queue of entries plus the pending-load record.
   typedef struct {
      logic [127:0] b;
      logic [4:0]   s0;
      logic [4:0]   s1;
      logic [1:0]   u;
   } ent_t;

   ent_t         q[$];
   int           ld_cnt;
   logic [4:0]   ld_dst;
   logic [127:0] last_out;
   logic         armed;
   int           errors = 0;
   int           checks = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic exp_nz(input logic [127:0] b);
`ifdef ID_ISSUE_EXP_EN
      return b[ISA_EXP_LSB +: ISA_EXP_W] != 3'd0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [127:0] present(input logic [127:0] b);
      logic [127:0] r;
      r = b;
`ifdef ID_ISSUE_EXP_EN
      if (exp_nz(b)) r[ISA_GPR_WE_N_BIT] = 1'b1;
`else
      r[ISA_EXP_LSB +: ISA_EXP_W] = 3'd0;
`endif
      return r;
   endfunction

   function automatic logic model_hazard();
      if (q.size() == 0 || ld_cnt == 0 || ld_dst == 5'd0 || exp_nz(q[0].b)) return 1'b0;
      return (q[0].u[0] && q[0].s0 == ld_dst) || (q[0].u[1] && q[0].s1 == ld_dst);
   endfunction

   function automatic logic [127:0] mk(input logic [2:0] mop, input logic [4:0] dst,
                                       input logic we_n, input logic [2:0] ex);
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      r[ISA_MEM_OP_LSB +: ISA_MEM_OP_W] = mop;
      r[ISA_DST_LSB +: ISA_DST_W]       = dst;
      r[ISA_GPR_WE_N_BIT]               = we_n;
      r[ISA_EXP_LSB +: ISA_EXP_W]       = ex;
      return r;
   endfunction

   task automatic check_model();
      logic hz;
      hz = model_hazard();
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      chk("dec_ready", 128'(dec_ready), 128'(q.size() < DEPTH));
      chk("ex_valid", 128'(ex_valid), 128'(q.size() != 0 && !hz));
      chk("ld_hazard", 128'(ld_hazard), 128'(hz));
      chk("ex_bundle", ex_bundle, (q.size() != 0) ? present(q[0].b) : last_out);
   endtask

   task automatic model_edge(input logic dv, input logic [127:0] b, input logic [4:0] s0, s1,
                             input logic [1:0] u, input logic er, fl, rs);
      logic hz, pv, pu;
      ent_t e, h;
      if (rs) begin
         q.delete(); ld_cnt = 0; ld_dst = 5'd0; last_out = '0;
         return;
      end
      hz = model_hazard();
      pv = (q.size() != 0) && !hz && er;
      pu = dv && (q.size() < DEPTH) && !fl;
      if (q.size() != 0) last_out = present(q[0].b);
      if (fl) begin
         q.delete(); ld_cnt = 0; ld_dst = 5'd0;
         return;
      end
      if (pv) begin
         h = q.pop_front();
         if (h.b[ISA_MEM_OP_LSB +: ISA_MEM_OP_W] == 3'(MEM_OP_LOAD) &&
             !h.b[ISA_GPR_WE_N_BIT] && !exp_nz(h.b)) begin
            ld_dst = h.b[ISA_DST_LSB +: ISA_DST_W];
            ld_cnt = LD_LAT;
         end else if (ld_cnt > 0) begin
            ld_cnt--;
         end
      end else if (ld_cnt > 0) begin
         ld_cnt--;
      end
      if (pu) begin
         e.b = b; e.s0 = s0; e.s1 = s1; e.u = u;
         q.push_back(e);
      end
   endtask

   // One clock: drive at posedge+1, check model at negedge, update at posedge.
   task automatic step(input logic dv, input logic [127:0] b, input logic [4:0] s0, s1,
                       input logic [1:0] u, input logic er, fl, rs);
      dec_valid = dv; dec_bundle = b; dec_src0 = s0; dec_src1 = s1;
      dec_src_use = u; ex_ready = er; flush = fl; reset = rs;
      @(negedge clk);
      if (armed) check_model();
      @(posedge clk);
      model_edge(dv, b, s0, s1, u, er, fl, rs);
      #1;
   endtask

   logic [127:0] b4 [4];
   logic [127:0] bL, bD, bX, bE;
   logic [2:0]   mop, rex;

   initial begin
      armed = 1'b0; ld_cnt = 0; ld_dst = 5'd0; last_out = '0;
      step(0, Z, 0, 0, 0, 0, 0, 1);
      step(1, mk(3'(MEM_OP_LOAD), 5'd3, 0, 0), 3, 3, 2'b11, 1, 1, 1);
      armed = 1'b1;

      chk("rst_occupancy", 128'(occupancy), 128'(0));
      chk("rst_ex_valid", 128'(ex_valid), 128'(0));
      chk("rst_dec_ready", 128'(dec_ready), 128'(1));
      chk("rst_ex_bundle", ex_bundle, Z);
      chk("rst_ld_hazard", 128'(ld_hazard), 128'(0));

      // Fill to full with the consumer stalled, then drain in order.
      for (int i = 0; i < 4; i++) begin
         b4[i] = mk(3'(MEM_OP_NONE), 5'(i + 1), 1'b1, 3'd0);
         step(1, b4[i], 0, 0, 2'b00, 0, 0, 0);
      end
      chk("full_occupancy", 128'(occupancy), 128'(4));
      chk("full_dec_ready", 128'(dec_ready), 128'(0));
      for (int i = 0; i < 4; i++) begin
         chk("order_ex_valid", 128'(ex_valid), 128'(1));
         chk("order_ex_bundle", ex_bundle, b4[i]);
         step(i == 0, mk(3'(MEM_OP_NONE), 5'd9, 1'b1, 3'd0), 0, 0, 2'b00, 1, 0, 0);
      end
      chk("drained_occupancy", 128'(occupancy), 128'(0));
      chk("drained_holds_last", ex_bundle, b4[3]);

      // Load to r3, then a dependent head: two stall cycles with LD_LAT=2.
      bL = mk(3'(MEM_OP_LOAD), 5'd3, 1'b0, 3'd0);
      bD = mk(3'(MEM_OP_NONE), 5'd7, 1'b1, 3'd0);
      step(1, bL, 0, 0, 2'b00, 0, 0, 0);
      step(1, bD, 5'd3, 5'd0, 2'b01, 1, 0, 0);
      chk("lu_t1_ex_valid", 128'(ex_valid), 128'(0));
      chk("lu_t1_ld_hazard", 128'(ld_hazard), 128'(1));
      step(0, Z, 0, 0, 0, 1, 0, 0);
      chk("lu_t2_ex_valid", 128'(ex_valid), 128'(0));
      chk("lu_t2_ld_hazard", 128'(ld_hazard), 128'(1));
      step(0, Z, 0, 0, 0, 1, 0, 0);
      chk("lu_t3_ex_valid", 128'(ex_valid), 128'(1));
      chk("lu_t3_ld_hazard", 128'(ld_hazard), 128'(0));
      chk("lu_t3_ex_bundle", ex_bundle, bD);
      step(0, Z, 0, 0, 0, 1, 0, 0);

      // Load to r0 never stalls its consumer.
      step(1, mk(3'(MEM_OP_LOAD), 5'd0, 1'b0, 3'd0), 0, 0, 2'b00, 0, 0, 0);
      step(1, mk(3'(MEM_OP_NONE), 5'd5, 1'b1, 3'd0), 5'd0, 5'd0, 2'b11, 1, 0, 0);
      chk("r0_ex_valid", 128'(ex_valid), 128'(1));
      chk("r0_ld_hazard", 128'(ld_hazard), 128'(0));
      step(0, Z, 0, 0, 0, 1, 0, 0);

      // Flush with three queued and a bundle offered in the same cycle.
      for (int i = 0; i < 3; i++) step(1, mk(3'(MEM_OP_NONE), 5'd1, 1'b1, 3'd0), 0, 0, 2'b00, 0, 0, 0);
      bX = mk(3'(MEM_OP_NONE), 5'd9, 1'b1, 3'd0);
      step(1, bX, 0, 0, 2'b00, 1, 1, 0);
      chk("flush_occupancy", 128'(occupancy), 128'(0));
      chk("flush_ex_valid", 128'(ex_valid), 128'(0));
      for (int i = 0; i < 3; i++) begin
         step(0, Z, 0, 0, 0, 1, 0, 0);
         chk("flush_dropped_hidden", 128'(ex_bundle === bX), 128'(0));
      end

      // Reset in the middle of an interlock.
      step(1, bL, 0, 0, 2'b00, 0, 0, 0);
      step(1, bD, 5'd3, 5'd0, 2'b01, 1, 0, 0);
      chk("mid_lock_ld_hazard", 128'(ld_hazard), 128'(1));
      step(0, Z, 0, 0, 0, 1, 0, 1);
      chk("rst2_occupancy", 128'(occupancy), 128'(0));
      chk("rst2_ex_valid", 128'(ex_valid), 128'(0));
      chk("rst2_dec_ready", 128'(dec_ready), 128'(1));
      chk("rst2_ex_bundle", ex_bundle, Z);
      chk("rst2_ld_hazard", 128'(ld_hazard), 128'(0));
      step(1, bD, 5'd3, 5'd0, 2'b01, 0, 0, 0);
      chk("post_rst_ex_valid", 128'(ex_valid), 128'(1));
      step(0, Z, 0, 0, 0, 1, 0, 0);

`ifdef ID_ISSUE_EXP_EN
      bE = mk(3'(MEM_OP_LOAD), 5'd4, 1'b0, 3'd2);
      step(1, bL, 0, 0, 2'b00, 0, 0, 0);
      step(1, bE, 5'd3, 5'd0, 2'b01, 1, 0, 0);
      chk("exp_ex_valid", 128'(ex_valid), 128'(1));
      chk("exp_ld_hazard", 128'(ld_hazard), 128'(0));
      chk("exp_gpr_we_n", 128'(ex_bundle[ISA_GPR_WE_N_BIT]), 128'(1));
      step(0, Z, 0, 0, 0, 1, 0, 0);
`else
      bE = mk(3'(MEM_OP_NONE), 5'd4, 1'b0, 3'd2);
      step(1, bE, 0, 0, 2'b00, 0, 0, 0);
      chk("exp_off_field", 128'(ex_bundle[ISA_EXP_LSB +: ISA_EXP_W]), 128'(ISA_EXP_NO_EXP));
      step(0, Z, 0, 0, 0, 1, 0, 0);
`endif

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         mop = ($urandom_range(0, 1) != 0) ? 3'(MEM_OP_LOAD) : 3'($urandom_range(0, 7));
         rex = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         step($urandom_range(0, 3) != 0,
              mk(mop, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rex),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
      end
      for (int i = 0; i < 8; i++) step(0, Z, 0, 0, 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
